// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU); PPC digits per cycle into carry-save sum/carry.
// Latency: resp_valid rises NCYC = ceil((XLEN/2+1)/PPC) edges after the accepting edge; result registered.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready. Optional BOOTH_MUL_ACC_EN adds x*y+acc.
`timescale 1ns/1ps
module booth_mul_iter #(
  parameter int XLEN = 32,
  parameter int PPC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_x_sgn,
  input  logic              req_y_sgn,
  input  logic [XLEN-1:0]   req_x,
  input  logic [XLEN-1:0]   req_y,
  input  logic              req_kill,
`ifdef BOOTH_MUL_ACC_EN
  input  logic              req_acc_en,
  input  logic [2*XLEN-1:0] req_acc,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_hi,
  output logic [XLEN-1:0]   resp_lo
);

  localparam int NDIG = XLEN / 2 + 1;
  localparam int NCYC = (NDIG + PPC - 1) / PPC;
  localparam int XW   = XLEN + 2;            // extended multiplicand
  localparam int PW   = XLEN + 3;            // partial product, holds +-2x
  localparam int P2   = 2 * XLEN;            // product / accumulator width
  localparam int YW   = 2 * PPC * NCYC + 1;  // multiplier window incl. the y[-1] bit
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  // Sum of the sign-extension-prevention constants of all NDIG partial products.
  // Each product is added with its MSB inverted, which over-counts by 2^(PW-1) at its weight.
  function automatic logic [P2-1:0] sep_const();
    logic [P2-1:0] k;
    k = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (PW - 1 + 2 * i < P2) k = k - (P2'(1) << (PW - 1 + 2 * i));
    end
    return k;
  endfunction

  localparam logic [P2-1:0] SEP_K = sep_const();

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            y_fill;
  logic [CW-1:0]   cnt;
  logic [P2-1:0]   sum_q, carry_q;
  logic            last;
  logic            y_ext;

  // Combinational datapath temporaries
  logic [P2-1:0]   s, c, t, addend, negv, sum_nx, carry_nx, prod;
  logic [2:0]      dig;
  logic            one, two, neg;
  logic [PW-1:0]   mag, pp;
  int              idx;

  assign last  = (cnt == CW'(NCYC - 1));
  assign y_ext = req_y_sgn & req_y[XLEN-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (req_kill)  state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Booth recode PPC digits, compress them into sum/carry with 3:2 stages, and form the final sum
  always_comb begin
    s      = sum_q;
    c      = carry_q;
    t      = '0;
    addend = '0;
    negv   = '0;
    dig    = '0;
    one    = 1'b0;
    two    = 1'b0;
    neg    = 1'b0;
    mag    = '0;
    pp     = '0;
    idx    = 0;
    for (int j = 0; j < PPC; j++) begin
      idx    = int'(cnt) * PPC + j;
      dig    = y_q[2*j +: 3];
      one    = dig[1] ^ dig[0];
      two    = (dig == 3'b011) || (dig == 3'b100);
      neg    = dig[2] & ~(dig[1] & dig[0]);
      mag    = one ? {x_q[XW-1], x_q} : (two ? {x_q, 1'b0} : '0);
      pp     = neg ? ~mag : mag;
      addend = '0;
      // Digit slots past the last Booth digit contribute nothing
      if (idx < NDIG) begin
        addend = P2'({~pp[PW-1], pp[PW-2:0]}) << (2 * idx);
        negv   = negv | (P2'(neg) << (2 * idx));
      end
      t = s ^ c ^ addend;
      c = ((s & c) | (s & addend) | (c & addend)) << 1;
      s = t;
    end
    // Two's-complement +1 for every negated digit, all at distinct even positions
    t        = s ^ c ^ negv;
    c        = ((s & c) | (s & negv) | (c & negv)) << 1;
    s        = t;
    sum_nx   = s;
    carry_nx = c;
    prod     = s + c;
  end

  // Operand latch, iteration state and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      y_fill  <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      resp_hi <= '0;
      resp_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_q     <= {{2{req_x_sgn & req_x[XLEN-1]}}, req_x};
            y_q     <= {{(YW - 1 - XLEN){y_ext}}, req_y, 1'b0};
            y_fill  <= y_ext;
            cnt     <= '0;
`ifdef BOOTH_MUL_ACC_EN
            sum_q   <= req_acc_en ? req_acc : '0;
`else
            sum_q   <= '0;
`endif
            carry_q <= SEP_K;
          end
        end
        BUSY: begin
          if (!req_kill) begin
            sum_q   <= sum_nx;
            carry_q <= carry_nx;
            y_q     <= {{(2 * PPC){y_fill}}, y_q[YW-1:2*PPC]};
            cnt     <= cnt + 1'b1;
            if (last) begin
              resp_hi <= prod[P2-1:XLEN];
              resp_lo <= prod[XLEN-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed bench for booth_mul_iter (XLEN=32, PPC=2) plus PPC sweep instances.
// Inputs are driven 1ns after the rising edge and outputs are sampled at the same point.
// Each test task performs its own comparisons.
`timescale 1ns/1ps
module tb_booth_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_ready, req_x_sgn, req_y_sgn, req_kill;
  logic        resp_valid, resp_ready;
  logic [31:0] req_x, req_y, resp_hi, resp_lo;
`ifdef BOOTH_MUL_ACC_EN
  logic        req_acc_en;
  logic [63:0] req_acc;
`endif

  int checks   = 0;
  int failures = 0;

  booth_mul_iter #(.XLEN(32), .PPC(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x_sgn(req_x_sgn), .req_y_sgn(req_y_sgn),
    .req_x(req_x), .req_y(req_y), .req_kill(req_kill),
`ifdef BOOTH_MUL_ACC_EN
    .req_acc_en(req_acc_en), .req_acc(req_acc),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo)
  );

  function automatic int sw_ppc(int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 17;
    endcase
  endfunction

  logic        sw_req_valid;
  logic [3:0]  sw_req_ready, sw_resp_valid;
  logic [31:0] sw_hi [4];
  logic [31:0] sw_lo [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    booth_mul_iter #(.XLEN(32), .PPC(sw_ppc(g))) u_sw (
      .clk(clk), .reset(reset),
      .req_valid(sw_req_valid), .req_ready(sw_req_ready[g]),
      .req_x_sgn(req_x_sgn), .req_y_sgn(req_y_sgn),
      .req_x(req_x), .req_y(req_y), .req_kill(1'b0),
`ifdef BOOTH_MUL_ACC_EN
      .req_acc_en(1'b0), .req_acc(64'd0),
`endif
      .resp_valid(sw_resp_valid[g]), .resp_ready(1'b1),
      .resp_hi(sw_hi[g]), .resp_lo(sw_lo[g])
    );
  end

  // Present one request for a single edge (assumes the DUT is idle)
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic xs, input logic ys);
    req_x = x; req_y = y; req_x_sgn = xs; req_y_sgn = ys; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Edges from accept until resp_valid; -1 when the bound expires
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_hi !== 32'h0)   begin failures++; $display("FAIL reset_hi: got %h want 0", resp_hi); end
    checks++; if (resp_lo !== 32'h0)   begin failures++; $display("FAIL reset_lo: got %h want 0", resp_lo); end
  endtask

  task automatic test_products();
    logic [31:0] tx [11];
    logic [31:0] ty [11];
    logic        txs [11];
    logic        tys [11];
    logic [63:0] texp [11];
    int lat;
    tx[0]  = 32'hFFFFFFFF; ty[0]  = 32'hFFFFFFFF; txs[0]  = 1; tys[0]  = 1; texp[0]  = 64'h00000000_00000001;
    tx[1]  = 32'hFFFFFFFF; ty[1]  = 32'hFFFFFFFF; txs[1]  = 0; tys[1]  = 0; texp[1]  = 64'hFFFFFFFE_00000001;
    tx[2]  = 32'hFFFFFFFF; ty[2]  = 32'hFFFFFFFF; txs[2]  = 1; tys[2]  = 0; texp[2]  = 64'hFFFFFFFF_00000001;
    tx[3]  = 32'hFFFFFFFF; ty[3]  = 32'hFFFFFFFF; txs[3]  = 0; tys[3]  = 1; texp[3]  = 64'hFFFFFFFF_00000001;
    tx[4]  = 32'h80000000; ty[4]  = 32'h80000000; txs[4]  = 1; tys[4]  = 1; texp[4]  = 64'h40000000_00000000;
    tx[5]  = 32'h80000000; ty[5]  = 32'h7FFFFFFF; txs[5]  = 1; tys[5]  = 1; texp[5]  = 64'hC0000000_80000000;
    tx[6]  = 32'hFFFFFFF9; ty[6]  = 32'h00000006; txs[6]  = 1; tys[6]  = 1; texp[6]  = 64'hFFFFFFFF_FFFFFFD6;
    tx[7]  = 32'h00000003; ty[7]  = 32'h00000005; txs[7]  = 0; tys[7]  = 0; texp[7]  = 64'h00000000_0000000F;
    tx[8]  = 32'hFFFFFFFF; ty[8]  = 32'h00000002; txs[8]  = 0; tys[8]  = 0; texp[8]  = 64'h00000001_FFFFFFFE;
    tx[9]  = 32'h80000000; ty[9]  = 32'h80000000; txs[9]  = 0; tys[9]  = 0; texp[9]  = 64'h40000000_00000000;
    tx[10] = 32'h80000000; ty[10] = 32'hFFFFFFFF; txs[10] = 1; tys[10] = 1; texp[10] = 64'h00000000_80000000;
    for (int i = 0; i < 11; i++) begin
      issue(tx[i], ty[i], txs[i], tys[i]);
      wait_resp(lat);
      checks++;
      if (lat != 9) begin failures++; $display("FAIL prod_latency[%0d]: got %0d want 9", i, lat); end
      checks++;
      if ({resp_hi, resp_lo} !== texp[i]) begin
        failures++; $display("FAIL prod_value[%0d]: got %h want %h", i, {resp_hi, resp_lo}, texp[i]);
      end
      consume();
    end
  endtask

  task automatic test_hold_back_to_back();
    int lat;
    int bad;
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    wait_resp(lat);
    bad = 0;
    // Hold off the consumer; a kill and a competing request along the way must change nothing
    for (int k = 0; k < 5; k++) begin
      req_kill  = (k == 1);
      req_valid = (k == 2);
      req_x     = 32'h12345678;
      @(posedge clk); #1;
      if (!resp_valid || req_ready || resp_hi !== 32'h0 || resp_lo !== 32'd15) bad++;
    end
    req_kill = 1'b0; req_valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_stable: unstable cycles got %0d want 0", bad); end
    // Handshake and next request presented together
    req_x = 32'hFFFFFFFF; req_y = 32'hFFFFFFFF; req_x_sgn = 1'b1; req_y_sgn = 1'b1;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_idle: got valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept: got ready=%b want 0", req_ready); end
    wait_resp(lat);
    checks++;
    if (lat != 9 || {resp_hi, resp_lo} !== 64'h1) begin
      failures++; $display("FAIL b2b_result: got lat=%0d val=%h want lat=9 val=1", lat, {resp_hi, resp_lo});
    end
    consume();
  endtask

  task automatic test_kill();
    int seen;
    int lat;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    req_kill = 1'b1;
    @(posedge clk); #1;
    req_kill = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hi !== 32'h0 || resp_lo !== 32'h1) begin
      failures++;
      $display("FAIL kill_idle: got ready=%b valid=%b val=%h want ready=1 valid=0 val=1",
               req_ready, resp_valid, {resp_hi, resp_lo});
    end
    seen = 0;
    for (int n = 0; n < 12; n++) begin @(posedge clk); #1; if (resp_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL kill_no_resp: got %0d valid cycles want 0", seen); end
    // Kill alongside a request in IDLE: the request wins
    req_kill = 1'b1;
    issue(32'd7, 32'd9, 1'b0, 1'b0);
    req_kill = 1'b0;
    wait_resp(lat);
    checks++;
    if (lat != 9 || {resp_hi, resp_lo} !== 64'd63) begin
      failures++; $display("FAIL kill_idle_accept: got lat=%0d val=%h want lat=9 val=3f", lat, {resp_hi, resp_lo});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hi !== 32'h0 || resp_lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got ready=%b valid=%b val=%h want ready=1 valid=0 val=0",
               req_ready, resp_valid, {resp_hi, resp_lo});
    end
    seen = 0;
    resp_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin @(posedge clk); #1; if (resp_valid) seen++; end
    resp_ready = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_mid_no_resp: got %0d valid cycles want 0", seen); end
    issue(32'hFFFFFFFE, 32'd5, 1'b1, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat != 9 || {resp_hi, resp_lo} !== 64'hFFFFFFFF_FFFFFFF6) begin
      failures++; $display("FAIL reset_recover: got lat=%0d val=%h want lat=9 val=fffffffffffffff6", lat, {resp_hi, resp_lo});
    end
    consume();
  endtask

  task automatic test_ppc_sweep();
    int          lat [4];
    logic [63:0] val [4];
    int          exp_lat [4];
    exp_lat[0] = 17; exp_lat[1] = 6; exp_lat[2] = 5; exp_lat[3] = 1;
    for (int g = 0; g < 4; g++) begin lat[g] = -1; val[g] = '0; end
    req_x = 32'h80000000; req_y = 32'h80000000; req_x_sgn = 1'b1; req_y_sgn = 1'b1;
    sw_req_valid = 1'b1;
    @(posedge clk); #1;
    sw_req_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (sw_resp_valid[g] && lat[g] < 0) begin
          lat[g] = n;
          val[g] = {sw_hi[g], sw_lo[g]};
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (lat[g] != exp_lat[g]) begin
        failures++; $display("FAIL sweep_latency[ppc=%0d]: got %0d want %0d", sw_ppc(g), lat[g], exp_lat[g]);
      end
      checks++;
      if (val[g] !== 64'h40000000_00000000) begin
        failures++; $display("FAIL sweep_value[ppc=%0d]: got %h want 4000000000000000", sw_ppc(g), val[g]);
      end
    end
    checks++;
    if (sw_req_ready !== 4'hF) begin failures++; $display("FAIL sweep_idle: got %b want 1111", sw_req_ready); end
  endtask

`ifdef BOOTH_MUL_ACC_EN
  task automatic test_acc();
    int lat;
    req_acc_en = 1'b1;
    req_acc    = 64'd10;
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    wait_resp(lat);
    checks++;
    if (lat != 9 || {resp_hi, resp_lo} !== 64'd25) begin
      failures++; $display("FAIL acc_add: got lat=%0d val=%h want lat=9 val=19", lat, {resp_hi, resp_lo});
    end
    consume();
    req_acc = {64{1'b1}};
    issue(32'd1, 32'd1, 1'b0, 1'b0);
    wait_resp(lat);
    checks++;
    if ({resp_hi, resp_lo} !== 64'd0) begin
      failures++; $display("FAIL acc_wrap: got %h want 0", {resp_hi, resp_lo});
    end
    consume();
    req_acc_en = 1'b0;
    req_acc    = '0;
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_kill = 1'b0; resp_ready = 1'b0;
    req_x = '0; req_y = '0; req_x_sgn = 1'b0; req_y_sgn = 1'b0; sw_req_valid = 1'b0;
`ifdef BOOTH_MUL_ACC_EN
    req_acc_en = 1'b0; req_acc = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_products();
    test_hold_back_to_back();
    test_kill();
    test_reset_mid();
    test_ppc_sweep();
`ifdef BOOTH_MUL_ACC_EN
    test_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
